// File: rtl/add_pkg.sv
// add_pkg: shared width, op-select encodings and result-flag struct for the add datapath
package add_pkg;
  localparam int WIDTH = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;
endpackage

// File: rtl/add_ripple.sv
// add_ripple: combinational ripple-carry adder; x,y,cin in; s, cout and carry into the MSB (c_msb) out
module add_ripple #(
  parameter int WIDTH = add_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout  = c[WIDTH];
  assign c_msb = c[WIDTH-1];
endmodule

// File: rtl/add.sv
// add: registered add/sub (clk, rst_n sync active-low; a, b, sub, in_valid in; result, carry, overflow, zero, out_valid out, 1-cycle latency)
module add
  import add_pkg::*;
#(
  parameter int WIDTH = add_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             c_msb;
  flags_t           f;
  assign is_sub = sub == OP_SUB;
  assign b_eff  = b ^ {WIDTH{is_sub}};
  add_ripple #(.WIDTH(WIDTH)) u_ripple (
    .x(a),
    .y(b_eff),
    .cin(is_sub),
    .s(s),
    .cout(cout),
    .c_msb(c_msb)
  );
  assign f = '{carry: cout, overflow: c_msb ^ cout, zero: s == '0};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result                   <= s;
        {carry, overflow, zero}  <= f;
      end
    end
  end
endmodule

// File: tb/tb_add.sv
// tb_add: randomized scoreboard bench for add against an integer-arithmetic reference model
module tb_add;
  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       sub = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] result;
  logic       carry, overflow, zero, out_valid;

  exp_t q[$];
  exp_t held = '{8'h00, 1'b0, 1'b0, 1'b0};
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  add #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub), .in_valid(in_valid),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t e;
    int ux = int'(x), uy = int'(y);
    int sx = int'($signed(x)), sy = int'($signed(y));
    int ur = s ? ux - uy : ux + uy;
    int sr = s ? sx - sy : sx + sy;
    e.r = 8'((ur % 256 + 256) % 256);
    e.c = s ? (ux >= uy) : (ur > 255);
    e.o = (sr > 127) || (sr < -128);
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        held = q.pop_front();
        chk("out_valid", {7'b0, out_valid}, 8'h01);
      end else begin
        chk("out_valid", {7'b0, out_valid}, 8'h00);
      end
      chk("result", result, held.r);
      chk("carry", {7'b0, carry}, {7'b0, held.c});
      chk("overflow", {7'b0, overflow}, {7'b0, held.o});
      chk("zero", {7'b0, zero}, {7'b0, held.z});
    end
  end

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s, input logic v, input logic rn);
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    a        = v ? x : 8'hxx;
    b        = v ? y : 8'hxx;
    sub      = v ? s : 1'bx;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      held   = '{8'h00, 1'b0, 1'b0, 1'b0};
      mon_en = 1'b1;
    end else if (v) begin
      q.push_back(model(x, y, s));
    end
  endtask

  initial begin
    repeat (3) op(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    op(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    op(8'h01, 8'h05, 1'b0, 1'b1, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    op(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    op(8'h05, 8'h03, 1'b1, 1'b1, 1'b1);
    op(8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
    op(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) op(8'(i), 8'(i), 1'b0, 1'b1, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
    op(8'h02, 8'h02, 1'b0, 1'b1, 1'b1);
    op(8'h03, 8'h03, 1'b0, 1'b1, 1'b0);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++)
      op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) != 0));
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add.md
Name: add

Overview:
- Registered 8-bit integer adder/subtractor for the calculator datapath.
- Takes two operands `a` and `b`, computes a sum or difference, and presents the result with status flags one clock after a valid input.
- Sits between operand entry/decode and the result display/select logic.

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  WIDTH  operand A, unsigned or two's complement (same bits, different flags).
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- in_valid  input  1  operands and sub are sampled this cycle.
- result  output  WIDTH  registered sum or difference, modulo 2^WIDTH.
- carry  output  1  unsigned carry-out; for subtract, 1 means no borrow (A>=B unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.
- out_valid  output  1  result and flags correspond to the operands sampled last cycle.

Behaviour:
- Reset (rst_n low at a rising clk edge):
  - result = 0, carry = 0, overflow = 0, zero = 0, out_valid = 0.
  - Reset overrides in_valid in the same cycle. An operation pending at the reset edge is discarded.
- Arithmetic:
  - Compute {carry, result} = a + (b XOR {WIDTH{sub}}) + sub, i.e. a (WIDTH+1)-bit sum.
  - Implemented as a ripple-carry chain through the sub-module.
  - overflow = (a[MSB] == b_eff[MSB]) AND (result[MSB] != a[MSB]), where b_eff = b XOR {WIDTH{sub}}.
  - zero = (result == 0), computed on the new result.
- Latency:
  - When in_valid = 1 at edge N, result, carry, overflow and zero load at edge N, and out_valid = 1 after edge N.
  - Latency is exactly 1 cycle. Throughput is one operation per cycle, back-to-back.
- When in_valid = 0 at an edge:
  - out_valid = 0.
  - result and flags hold their previous values (no clear).
- There is no backpressure. The downstream block must capture the result in the cycle out_valid = 1.
- Boundary conditions:
  - 8'hFF + 8'h01 -> result 0, carry 1, zero 1, overflow 0.
  - 8'h7F + 8'h01 -> result 8'h80, overflow 1, carry 0.
  - 8'h00 - 8'h01 -> result 8'hFF, carry 0 (borrow), overflow 0.
  - 8'h80 - 8'h01 -> result 8'h7F, overflow 1, carry 1.
- X on the inputs while in_valid = 0 must not propagate to the outputs.

Decomposition:
- Package add_pkg:
  - WIDTH default constant.
  - Op-select encodings: OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Packed result-flags struct {carry, overflow, zero}.
- One sub-module, add_ripple:
  - Combinational WIDTH-bit ripple-carry adder built from per-bit full-adder logic.
  - Inputs: x, y, cin. Outputs: s, cout, and carry into the MSB (for overflow).
- The top level add contains the operand inversion, flag logic and output registers.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 and a = 8'h12, b = 8'h34 -> all outputs 0 and out_valid = 0 throughout. First edge after release -> result 8'h46, out_valid 1.
- Basic add: a = 8'h01, b = 8'h05, sub = 0, in_valid pulse -> next cycle result 8'h06, carry 0, overflow 0, zero 0, out_valid 1. Following idle cycle -> out_valid 0, result holds 8'h06.
- Carry/zero: a = 8'hFF, b = 8'h01, sub = 0 -> result 8'h00, carry 1, zero 1. Then a = 8'h7F, b = 8'h01 -> result 8'h80, overflow 1, carry 0.
- Subtract: a = 8'h05, b = 8'h03, sub = 1 -> result 8'h02, carry 1. Then a = 8'h00, b = 8'h01 -> result 8'hFF, carry 0. Then a = 8'h80, b = 8'h01 -> result 8'h7F, overflow 1.
- Back-to-back: in_valid high 4 cycles with (1,1), (2,2), (3,3), (4,4) -> results 2, 4, 6, 8 on consecutive cycles with out_valid continuously 1.
- Reset mid-stream: assert rst_n = 0 during the back-to-back sequence -> at that edge all outputs clear, and no result for the in-flight operation appears after release.
